rx: RTL and testbench

Receive-side counterpart of the tx transmitter. It drains the transmitter's two destination FIFOs (D0/D1) by issuing POP_D0/POP_D1 and accepting the returned words. Each word is steered by bit 5 into one of two virtual-channel buffers, VC0 or VC1. The buffers are then merged into a single registered output stream with downstream backpressure. A small control FSM reports IDLE/ACTIVE/ERROR, matching the tx control machine.

---
 rtl/rx_pkg.sv | 21 ++
 rtl/rx_vc_fifo.sv | 55 +++++
 rtl/rx.sv | 183 ++++++++++++++++++
 tb/tb_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants, FSM encoding and lane/VC ids for the rx block
package rx_pkg;

  // Word field positions
  localparam int VC_SEL_BIT = 5;
  localparam int DEST_BIT   = 4;

  // Control FSM encoding, shared with the tx control machine
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ERROR  = 2'b10
  } rx_state_t;

  // Lane and virtual-channel identifiers
  localparam logic LANE_D0 = 1'b0;
  localparam logic LANE_D1 = 1'b1;
  localparam logic VC_0    = 1'b0;
  localparam logic VC_1    = 1'b1;

endpackage

// File: rtl/rx_vc_fifo.sv
// rtl/rx_vc_fifo.sv - single virtual-channel buffer with occupancy count and overflow flag
module rx_vc_fifo #(
  parameter int WIDTH     = 6,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 wr_ok;
  logic                 rd_ok;

  // A write into a full buffer is refused even if a read happens in the same cycle
  assign full     = (count == (PTR_WIDTH + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ok    = wr_en & ~full;
  assign rd_ok    = rd_en & ~empty;
  assign overflow = wr_en & full;
  assign rd_data  = mem[rd_ptr];

  // Storage array: written only on an accepted write
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; an empty buffer never forwards a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx.sv
// rtl/rx.sv - lane pop arbiter, VC0/VC1 buffers, merged output stage and control FSM; RX_VC_RR_ARB_EN selects round-robin VC output arbitration
module rx
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int VC_DEPTH   = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DATA_IN_D0,
  input  logic                  VALID_D0,
  input  logic                  EMPTY_D0,
  output logic                  POP_D0,
  input  logic [DATA_WIDTH-1:0] DATA_IN_D1,
  input  logic                  VALID_D1,
  input  logic                  EMPTY_D1,
  output logic                  POP_D1,
  input  logic                  HOLD,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  VALID_OUT,
  output logic                  IDLE_OUT,
  output logic                  ACTIVE_OUT,
  output logic                  ERROR_OUT
);

  localparam int CW = PTR_WIDTH + 2;

  rx_state_t             state, state_n;
  logic                  lane_ptr;
  logic                  pop0_d, pop1_d;
  logic                  gnt0, gnt1;
  logic [CW-1:0]         pend;
  logic                  room;
  logic                  err_now;
  logic                  wr_lane0, wr_lane1;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  vc0_wr, vc1_wr;
  logic                  rd0, rd1;
  logic [DATA_WIDTH-1:0] q0, q1;
  logic [PTR_WIDTH:0]    occ0, occ1;
  logic                  full0, full1, empty0, empty1, ovf0, ovf1;
`ifdef RX_VC_RR_ARB_EN
  logic                  vc_ptr;
`endif

  rx_vc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(VC_DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_vc0 (
    .clk(clk), .rst(RESET), .wr_en(vc0_wr), .wr_data(wr_word), .rd_en(rd0),
    .rd_data(q0), .count(occ0), .full(full0), .empty(empty0), .overflow(ovf0)
  );

  rx_vc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(VC_DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_vc1 (
    .clk(clk), .rst(RESET), .wr_en(vc1_wr), .wr_data(wr_word), .rd_en(rd1),
    .rd_data(q1), .count(occ1), .full(full1), .empty(empty1), .overflow(ovf1)
  );

  // Words requested but not yet counted in occupancy: the POP on the wire now
  // and the one whose data is returning this cycle. Both VCs must have room
  // for all of them plus a new request because the destination VC is unknown.
  assign pend = CW'(POP_D0 | POP_D1) + CW'(pop0_d | pop1_d);
  assign room = ~full0 & ~full1
              & (CW'(occ0) + pend + CW'(1) <= CW'(VC_DEPTH))
              & (CW'(occ1) + pend + CW'(1) <= CW'(VC_DEPTH));

  // Accept returning words, steer by the VC select bit, and flag protocol errors
  always_comb begin
    wr_lane0 = VALID_D0 & ~VALID_D1 & pop0_d;
    wr_lane1 = VALID_D1 & ~VALID_D0 & pop1_d;
    wr_word  = wr_lane0 ? DATA_IN_D0 : DATA_IN_D1;
    vc0_wr   = (wr_lane0 | wr_lane1) & (wr_word[VC_SEL_BIT] == VC_0);
    vc1_wr   = (wr_lane0 | wr_lane1) & (wr_word[VC_SEL_BIT] == VC_1);
    err_now  = (VALID_D0 & VALID_D1) | (VALID_D0 & ~pop0_d) | (VALID_D1 & ~pop1_d)
             | ovf0 | ovf1;
  end

  // Lane grant: round-robin when both lanes are eligible, nothing once in ERROR
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_n != ST_ERROR && room) begin
      if (!EMPTY_D0 && !EMPTY_D1) begin
        if (lane_ptr == LANE_D0) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else if (!EMPTY_D0) begin
        gnt0 = 1'b1;
      end else if (!EMPTY_D1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // POP registers, their one-cycle-delayed copies and the lane pointer
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      POP_D0   <= 1'b0;
      POP_D1   <= 1'b0;
      pop0_d   <= 1'b0;
      pop1_d   <= 1'b0;
      lane_ptr <= LANE_D0;
    end else begin
      POP_D0 <= gnt0;
      POP_D1 <= gnt1;
      pop0_d <= POP_D0;
      pop1_d <= POP_D1;
      if (gnt0)      lane_ptr <= LANE_D1;
      else if (gnt1) lane_ptr <= LANE_D0;
    end
  end

  // Output-stage VC selection; HOLD blocks any VC read
  always_comb begin
    rd0 = 1'b0;
    rd1 = 1'b0;
    if (!HOLD) begin
`ifdef RX_VC_RR_ARB_EN
      if (!empty0 && (empty1 || vc_ptr == VC_0)) rd0 = 1'b1;
      else if (!empty1)                          rd1 = 1'b1;
`else
      if (!empty0)      rd0 = 1'b1;
      else if (!empty1) rd1 = 1'b1;
`endif
    end
  end

`ifdef RX_VC_RR_ARB_EN
  // VC round-robin pointer moves only when a word is actually emitted
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)    vc_ptr <= VC_0;
    else if (rd0) vc_ptr <= VC_1;
    else if (rd1) vc_ptr <= VC_0;
  end
`endif

  // Registered output word; frozen under HOLD, data kept when nothing to send
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      DATA_OUT  <= '0;
      VALID_OUT <= 1'b0;
    end else if (!HOLD) begin
      VALID_OUT <= rd0 | rd1;
      if (rd0)      DATA_OUT <= q0;
      else if (rd1) DATA_OUT <= q1;
    end
  end

  // Control FSM state register
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Control FSM next state; ERROR is left only through RESET
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (err_now) state_n = ST_ERROR;
        else if (!EMPTY_D0 || !EMPTY_D1 || !empty0 || !empty1) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_now) state_n = ST_ERROR;
        else if (empty0 && empty1 && EMPTY_D0 && EMPTY_D1 && !VALID_OUT
                 && !(POP_D0 | POP_D1 | pop0_d | pop1_d)) state_n = ST_IDLE;
      end
      ST_ERROR: state_n = ST_ERROR;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they are 0 in reset
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      IDLE_OUT   <= 1'b0;
      ACTIVE_OUT <= 1'b0;
      ERROR_OUT  <= 1'b0;
    end else begin
      IDLE_OUT   <= (state_n == ST_IDLE);
      ACTIVE_OUT <= (state_n == ST_ACTIVE);
      ERROR_OUT  <= (state_n == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_rx.sv
// tb/tb_rx.sv - self-checking bench for rx with a tx-lane responder and an arrival-time output model
module tb_rx;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [5:0] DATA_IN_D0 = '0, DATA_IN_D1 = '0;
  logic       VALID_D0 = 1'b0, VALID_D1 = 1'b0;
  logic       EMPTY_D0 = 1'b1, EMPTY_D1 = 1'b1;
  logic       HOLD = 1'b0;
  logic       POP_D0, POP_D1;
  logic [5:0] DATA_OUT;
  logic       VALID_OUT, IDLE_OUT, ACTIVE_OUT, ERROR_OUT;

  always #5 clk = ~clk;

  rx dut (
    .clk(clk), .RESET(RESET),
    .DATA_IN_D0(DATA_IN_D0), .VALID_D0(VALID_D0), .EMPTY_D0(EMPTY_D0), .POP_D0(POP_D0),
    .DATA_IN_D1(DATA_IN_D1), .VALID_D1(VALID_D1), .EMPTY_D1(EMPTY_D1), .POP_D1(POP_D1),
    .HOLD(HOLD), .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT),
    .IDLE_OUT(IDLE_OUT), .ACTIVE_OUT(ACTIVE_OUT), .ERROR_OUT(ERROR_OUT)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [5:0] lane_q0[$], lane_q1[$];
  logic       pend0, pend1;
  logic [5:0] pw0, pw1;
  bit         resp_en, chk_en;

  logic [5:0] m0[$], m1[$];
  int         a0[$], a1[$];
  logic       prev_valid;
  logic [5:0] prev_data;
`ifdef RX_VC_RR_ARB_EN
  logic       m_ptr;
`endif

  logic [5:0] outs[$];
  int         out_cyc[$];
  logic       pop_lane[$];

  task automatic push_lane(input logic lane, input logic [5:0] w);
    if (lane) begin lane_q1.push_back(w); EMPTY_D1 = 1'b0; end
    else      begin lane_q0.push_back(w); EMPTY_D0 = 1'b0; end
  endtask

  // One clock: record arrivals, check the output against the model, act as the tx lanes
  task automatic tick();
    logic       hold_c, exp_v, e0, e1;
    logic [5:0] exp_d;
    int         sel;
    @(posedge clk);
    hold_c = HOLD;
    if (VALID_D0) begin
      if (DATA_IN_D0[5]) begin m1.push_back(DATA_IN_D0); a1.push_back(cyc); end
      else               begin m0.push_back(DATA_IN_D0); a0.push_back(cyc); end
    end
    if (VALID_D1) begin
      if (DATA_IN_D1[5]) begin m1.push_back(DATA_IN_D1); a1.push_back(cyc); end
      else               begin m0.push_back(DATA_IN_D1); a0.push_back(cyc); end
    end
    #1;
    cyc++;
    exp_v = prev_valid;
    exp_d = prev_data;
    if (!hold_c) begin
      e0 = 1'b0; e1 = 1'b0;
      if (m0.size() > 0) e0 = (a0[0] <= cyc - 2);
      if (m1.size() > 0) e1 = (a1[0] <= cyc - 2);
      sel = -1;
`ifdef RX_VC_RR_ARB_EN
      if (e0 && (!e1 || m_ptr == 1'b0)) sel = 0;
      else if (e1)                      sel = 1;
      if (sel == 0) m_ptr = 1'b1;
      if (sel == 1) m_ptr = 1'b0;
`else
      if (e0)      sel = 0;
      else if (e1) sel = 1;
`endif
      exp_v = (sel >= 0);
      if (sel == 0) begin exp_d = m0.pop_front(); void'(a0.pop_front()); end
      if (sel == 1) begin exp_d = m1.pop_front(); void'(a1.pop_front()); end
      if (VALID_OUT === 1'b1) begin outs.push_back(DATA_OUT); out_cyc.push_back(cyc); end
    end
    if (chk_en) begin
      tests++;
      if (VALID_OUT !== exp_v || DATA_OUT !== exp_d) begin
        fails++;
        $display("FAIL out_stream cyc=%0d got valid=%b data=%b expected valid=%b data=%b",
                 cyc, VALID_OUT, DATA_OUT, exp_v, exp_d);
      end
    end
    prev_valid = exp_v;
    prev_data  = exp_d;
    if (resp_en) begin
      VALID_D0 = pend0; DATA_IN_D0 = pw0; pend0 = 1'b0;
      VALID_D1 = pend1; DATA_IN_D1 = pw1; pend1 = 1'b0;
      if (POP_D0 === 1'b1) begin
        pop_lane.push_back(1'b0);
        if (lane_q0.size() > 0) begin pw0 = lane_q0.pop_front(); pend0 = 1'b1; end
      end
      if (POP_D1 === 1'b1) begin
        pop_lane.push_back(1'b1);
        if (lane_q1.size() > 0) begin pw1 = lane_q1.pop_front(); pend1 = 1'b1; end
      end
      EMPTY_D0 = (lane_q0.size() == 0);
      EMPTY_D1 = (lane_q1.size() == 0);
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    HOLD = 1'b0; VALID_D0 = 1'b0; VALID_D1 = 1'b0; EMPTY_D0 = 1'b1; EMPTY_D1 = 1'b1;
    DATA_IN_D0 = '0; DATA_IN_D1 = '0;
    lane_q0.delete(); lane_q1.delete(); pend0 = 1'b0; pend1 = 1'b0; pw0 = '0; pw1 = '0;
    m0.delete(); m1.delete(); a0.delete(); a1.delete();
    outs.delete(); out_cyc.delete(); pop_lane.delete();
    prev_valid = 1'b0; prev_data = '0;
`ifdef RX_VC_RR_ARB_EN
    m_ptr = 1'b0;
`endif
    resp_en = 1'b1; chk_en = 1'b1; cyc = 0;
    @(posedge clk); #1;
    tests++;
    if ({POP_D0, POP_D1, VALID_OUT, IDLE_OUT, ACTIVE_OUT, ERROR_OUT, DATA_OUT} !== 12'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b expected all zero",
               {POP_D0, POP_D1, VALID_OUT, IDLE_OUT, ACTIVE_OUT, ERROR_OUT, DATA_OUT});
    end
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) tick();
    tests++; if (POP_D0 !== 1'b0 || POP_D1 !== 1'b0) begin fails++; $display("FAIL idle_pops got %b%b expected 00", POP_D0, POP_D1); end
    tests++; if (IDLE_OUT !== 1'b1)   begin fails++; $display("FAIL idle_out got %b expected 1", IDLE_OUT); end
    tests++; if (ACTIVE_OUT !== 1'b0) begin fails++; $display("FAIL idle_active got %b expected 0", ACTIVE_OUT); end
    tests++; if (VALID_OUT !== 1'b0)  begin fails++; $display("FAIL idle_valid got %b expected 0", VALID_OUT); end
    tests++; if (ERROR_OUT !== 1'b0)  begin fails++; $display("FAIL idle_error got %b expected 0", ERROR_OUT); end
  endtask

  task automatic test_single();
    int pc, act_seen;
    apply_reset();
    push_lane(1'b0, 6'b000101);
    pc = -1; act_seen = 0;
    for (int i = 0; i < 12 && outs.size() == 0; i++) begin
      tick();
      if (pc < 0 && pop_lane.size() > 0) begin pc = cyc; act_seen = (ACTIVE_OUT === 1'b1); end
    end
    tests++; if (pop_lane.size() != 1) begin fails++; $display("FAIL single_pops got %0d expected 1", pop_lane.size()); end
    tests++; if (act_seen != 1) begin fails++; $display("FAIL single_active got %0d expected 1", act_seen); end
    tests++;
    if (outs.size() != 1) begin
      fails++; $display("FAIL single_out_count got %0d expected 1", outs.size());
    end else begin
      if (outs[0] !== 6'b000101) begin fails++; $display("FAIL single_data got %b expected 000101", outs[0]); end
      tests++;
      if (out_cyc[0] - pc != 3) begin fails++; $display("FAIL single_latency got %0d expected 3", out_cyc[0] - pc); end
    end
    for (int i = 0; i < 10 && IDLE_OUT !== 1'b1; i++) tick();
    tests++; if (IDLE_OUT !== 1'b1) begin fails++; $display("FAIL single_back_to_idle got %b expected 1", IDLE_OUT); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] s0[$], s1[$], o0[$], o1[$];
    int bad;
    logic [5:0] w;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      w = 6'($urandom); w[5] = 1'b0; push_lane(1'b0, w); s0.push_back(w);
      w = 6'($urandom); w[5] = 1'b1; push_lane(1'b1, w); s1.push_back(w);
    end
    for (int i = 0; i < 80 && outs.size() < 16; i++) tick();
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= pop_lane.size() || pop_lane[i] !== 1'(i % 2)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_pop_alternation got %0d wrong grants expected 0", bad); end
    tests++; if (pop_lane.size() != 16) begin fails++; $display("FAIL b2b_pop_count got %0d expected 16", pop_lane.size()); end
    foreach (outs[i]) begin if (outs[i][5]) o1.push_back(outs[i]); else o0.push_back(outs[i]); end
    tests++; if (o0 != s0) begin fails++; $display("FAIL b2b_vc0_order got %0d words expected %0d in order", o0.size(), s0.size()); end
    tests++; if (o1 != s1) begin fails++; $display("FAIL b2b_vc1_order got %0d words expected %0d in order", o1.size(), s1.size()); end
    tests++; if (ERROR_OUT !== 1'b0) begin fails++; $display("FAIL b2b_error got %b expected 0", ERROR_OUT); end
  endtask

  task automatic test_hold_fill();
    logic [5:0] s[$];
    logic [5:0] w;
    int bad;
    apply_reset();
    HOLD = 1'b1;
    for (int i = 0; i < 20; i++) begin w = 6'($urandom); w[5] = 1'b1; push_lane(1'b1, w); s.push_back(w); end
    repeat (40) tick();
    tests++; if (pop_lane.size() != 16) begin fails++; $display("FAIL hold_pop_limit got %0d expected 16", pop_lane.size()); end
    tests++; if (ERROR_OUT !== 1'b0) begin fails++; $display("FAIL hold_no_overflow got %b expected 0", ERROR_OUT); end
    tests++; if (VALID_OUT !== 1'b0) begin fails++; $display("FAIL hold_valid got %b expected 0", VALID_OUT); end
    HOLD = 1'b0;
    for (int i = 0; i < 80 && outs.size() < 20; i++) tick();
    tests++; if (outs != s) begin fails++; $display("FAIL hold_drain_order got %0d words expected 20 in order", outs.size()); end
    bad = 0;
    for (int i = 1; i < 16; i++) if (i >= out_cyc.size() || out_cyc[i] != out_cyc[0] + i) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_continuous got %0d gaps expected 0", bad); end
  endtask

  task automatic test_vc_arb();
    logic [5:0] s0[$], s1[$], ex[$];
    logic [5:0] w;
    int bad;
    apply_reset();
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 6'($urandom); w[5] = 1'b0; push_lane(1'b0, w); s0.push_back(w);
      w = 6'($urandom); w[5] = 1'b1; push_lane(1'b1, w); s1.push_back(w);
    end
    repeat (20) tick();
`ifdef RX_VC_RR_ARB_EN
    for (int i = 0; i < 4; i++) begin ex.push_back(s0[i]); ex.push_back(s1[i]); end
`else
    ex = {s0, s1};
`endif
    HOLD = 1'b0;
    for (int i = 0; i < 30 && outs.size() < 8; i++) tick();
    tests++; if (outs != ex) begin fails++; $display("FAIL vc_arb_order got %0d words expected 8 in arbitration order", outs.size()); end
    bad = 0;
    for (int i = 1; i < 8; i++) if (i >= out_cyc.size() || out_cyc[i] != out_cyc[0] + i) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL vc_arb_continuous got %0d gaps expected 0", bad); end
  endtask

  task automatic test_error();
    int pops;
    apply_reset();
    resp_en = 1'b0; chk_en = 1'b0;
    tick();
    VALID_D1 = 1'b1; DATA_IN_D1 = 6'($urandom);
    tick();
    VALID_D1 = 1'b0;
    tests++; if (ERROR_OUT !== 1'b1) begin fails++; $display("FAIL error_unrequested got %b expected 1", ERROR_OUT); end
    resp_en = 1'b1;
    push_lane(1'b0, 6'b000011);
    push_lane(1'b1, 6'b100011);
    pops = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (POP_D0 !== 1'b0 || POP_D1 !== 1'b0) pops++; end
    tests++; if (pops != 0) begin fails++; $display("FAIL error_pops_blocked got %0d pops expected 0", pops); end
    tests++; if (ERROR_OUT !== 1'b1) begin fails++; $display("FAIL error_sticky got %b expected 1", ERROR_OUT); end
    apply_reset();
    tick();
    tests++; if (IDLE_OUT !== 1'b1 || ERROR_OUT !== 1'b0) begin fails++; $display("FAIL error_reset_recovery got idle=%b error=%b expected idle=1 error=0", IDLE_OUT, ERROR_OUT); end
  endtask

  task automatic test_random();
    int total;
    apply_reset();
    total = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) begin push_lane(1'b0, 6'($urandom)); total++; end
      if ($urandom_range(0, 2) == 0) begin push_lane(1'b1, 6'($urandom)); total++; end
      HOLD = ($urandom_range(0, 3) == 0);
      tick();
    end
    HOLD = 1'b0;
    for (int i = 0; i < 300 && outs.size() < total; i++) tick();
    tests++; if (outs.size() != total) begin fails++; $display("FAIL random_word_count got %0d expected %0d", outs.size(), total); end
    tests++; if (m0.size() + m1.size() != 0) begin fails++; $display("FAIL random_model_drained got %0d left expected 0", m0.size() + m1.size()); end
    tests++; if (ERROR_OUT !== 1'b0) begin fails++; $display("FAIL random_error got %b expected 0", ERROR_OUT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_fill();
    test_vc_arb();
    test_error();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
